// File: rtl/freq_monitor.sv
// rtl/freq_monitor.sv - clk_in period monitor with ACQ/TRACK/LOCKED/FAULT tracking
// FREQ_MONITOR_STICKY_EN: FAULT ignores ticks and is left only through clr_fault.
module freq_monitor #(
  parameter int EXP_PERIOD = 24000,
  parameter int TOL        = 16,
  parameter int LOCK_CNT   = 4
) (
  input  logic        CLK12MHZ,
  input  logic        rstn,
  input  logic        clk_in,
  input  logic        clr_fault,
  output logic        tick,
  output logic [23:0] period,
  output logic        period_valid,
  output logic        locked,
  output logic        fault
);

  typedef enum logic [1:0] {ACQ, TRACK, LOCKED, FAULT} state_t;

  localparam logic [23:0] WIN_LO  = 24'(EXP_PERIOD - TOL);
  localparam logic [23:0] WIN_HI  = 24'(EXP_PERIOD + TOL);
  localparam logic [23:0] TMO_CNT = 24'(EXP_PERIOD + TOL + 1);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_CNT);
  localparam logic [23:0] CNT_MAX = 24'hFFFFFF;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        edge_q, edge_d;
  logic        tick_q, tick_d;
  logic [23:0] cnt_q, cnt_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic [23:0] period_q, period_d;
  logic        period_valid_q, period_valid_d;
  logic        locked_q, locked_d;
  logic        fault_q, fault_d;
  logic [23:0] cnt_inc;
  logic        in_window;
  logic        timeout;

`ifndef FREQ_MONITOR_STICKY_EN
  logic unused_clr_fault;
  assign unused_clr_fault = clr_fault;
`endif

  always_comb begin
    sync1_d = clk_in;
    sync2_d = sync1_q;
    edge_d  = sync2_q;
    tick_d  = sync2_q & ~edge_q;

    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 24'd1;
    cnt_d     = tick_q ? 24'd1 : cnt_inc;
    in_window = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
    // Fires on the cycle the counter would step onto the first out-of-window value.
    timeout   = !tick_q && (cnt_inc == TMO_CNT);

    state_d        = state_q;
    good_cnt_d     = good_cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;

    if (tick_q && state_q != ACQ) begin
      period_d       = cnt_q;
      period_valid_d = 1'b1;
    end

    case (state_q)
      ACQ: begin
        if (tick_q) begin
          state_d    = TRACK;
          good_cnt_d = 4'd0;
        end
      end
      TRACK: begin
        if (tick_q) begin
          if (in_window) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_q + 4'd1 == LOCK_N) state_d = LOCKED;
          end else begin
            state_d    = FAULT;
            good_cnt_d = 4'd0;
          end
        end else if (timeout) begin
          state_d    = FAULT;
          good_cnt_d = 4'd0;
        end
      end
      LOCKED: begin
        if ((tick_q && !in_window) || timeout) begin
          state_d    = FAULT;
          good_cnt_d = 4'd0;
        end
      end
      FAULT: begin
`ifdef FREQ_MONITOR_STICKY_EN
        if (clr_fault) begin
          state_d    = ACQ;
          good_cnt_d = 4'd0;
        end
`else
        if (tick_q && in_window) begin
          good_cnt_d = 4'd1;
          state_d    = (LOCK_N == 4'd1) ? LOCKED : TRACK;
        end
`endif
      end
      default: state_d = ACQ;
    endcase

    locked_d = (state_d == LOCKED);
    fault_d  = (state_d == FAULT);
  end

  always_ff @(posedge CLK12MHZ or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ACQ;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      edge_q         <= 1'b0;
      tick_q         <= 1'b0;
      cnt_q          <= 24'd0;
      good_cnt_q     <= 4'd0;
      period_q       <= 24'd0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      edge_q         <= edge_d;
      tick_q         <= tick_d;
      cnt_q          <= cnt_d;
      good_cnt_q     <= good_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      fault_q        <= fault_d;
    end
  end

  assign tick         = tick_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign fault        = fault_q;

endmodule

// File: doc/freq_monitor.md
FREQ_MONITOR -- requirements
Module: freq_monitor

Interface
REQ-001 Parameter EXP_PERIOD, default 24000, expected clk_in period in CLK12MHZ cycles (500 Hz).
REQ-002 Parameter TOL, default 16, allowed +/- deviation in CLK12MHZ cycles.
REQ-003 Parameter LOCK_CNT, default 4, consecutive in-window periods to lock; legal range 1..15.
REQ-004 CLK12MHZ  input  1  system clock, 12 MHz.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 clk_in  input  1  slow clock under test, asynchronous to CLK12MHZ.
REQ-007 clr_fault  input  1  synchronous fault-clear pulse; used only with FREQ_MONITOR_STICKY_EN.
REQ-008 tick  output  1  one-cycle pulse per clk_in rising edge.
REQ-009 period  output  24  last measured clk_in period in CLK12MHZ cycles.
REQ-010 period_valid  output  1  one-cycle pulse when period updates.
REQ-011 locked  output  1  high in state LOCKED.
REQ-012 fault  output  1  high in state FAULT.

Function
REQ-013 clk_in SHALL pass a 2-flop synchronizer followed by an edge register; tick SHALL be high for exactly one cycle, on the 3rd CLK12MHZ rising edge after clk_in is first sampled high.
REQ-014 Cycle counter cnt (24 bit) SHALL load 1 on tick and otherwise increment, saturating at 24'hFFFFFF.
REQ-015 Period SHALL equal cycles between consecutive ticks; a 24000-cycle clk_in SHALL yield period=24000.
REQ-016 FSM states SHALL be ACQ, TRACK, LOCKED, FAULT; good_cnt is a 4-bit in-window period counter.
REQ-017 In-window SHALL mean EXP_PERIOD-TOL <= measured <= EXP_PERIOD+TOL, both bounds inclusive.
REQ-018 ACQ: first tick -> TRACK, cnt<=1, good_cnt<=0, no period_valid.
REQ-019 In TRACK, LOCKED and FAULT, each tick SHALL load period with cnt and pulse period_valid in the same cycle the FSM evaluates it.
REQ-020 TRACK: in-window tick -> good_cnt+1; when good_cnt reaches LOCK_CNT -> LOCKED; out-of-window tick -> FAULT, good_cnt<=0.
REQ-021 LOCKED: in-window tick stays LOCKED; out-of-window tick -> FAULT.
REQ-022 Timeout: in TRACK or LOCKED, cnt reaching EXP_PERIOD+TOL+1 without tick -> FAULT; period and period_valid are unchanged.
REQ-023 A tick and timeout in the same cycle SHALL be resolved by evaluating the tick only.
REQ-024 FAULT recovery without the macro: in-window tick -> TRACK with good_cnt=1 (-> LOCKED if LOCK_CNT=1); out-of-window tick stays FAULT.
REQ-025 Outputs locked and fault SHALL be registered decodes of state; never both high.

Reset
REQ-026 rstn low SHALL asynchronously force state=ACQ, sync flops=0, cnt=0, good_cnt=0, period=0, tick=0, period_valid=0, locked=0, fault=0.
REQ-027 Reset mid-measurement SHALL discard the partial period; the first tick after release re-enters via ACQ with no period_valid.

Configuration
REQ-028 Macro FREQ_MONITOR_STICKY_EN defined: FAULT SHALL be sticky, ignore ticks, and exit only on clr_fault=1 -> ACQ; period still updates on ticks.
REQ-029 Macro undefined: clr_fault SHALL be ignored and FAULT recovery follows REQ-024.

Verification
REQ-030 Defaults, clk_in period 24000 cycles -> tick every 24000 cycles; period=24000; locked=1 at the 5th tick.
REQ-031 While locked, one period of 24016, then one of 24017 -> first stays locked; second sets fault=1, period=24017.
REQ-032 While locked, clk_in stops -> fault=1 exactly 24017 cycles after the last tick; no period_valid.
REQ-033 With FREQ_MONITOR_STICKY_EN, after fault, 24000-cycle ticks keep fault=1; clr_fault pulse -> ACQ; locked again at the 5th subsequent tick.
REQ-034 Without the macro, after fault, 4 in-window periods -> locked=1 on the 4th in-window tick.
REQ-035 rstn pulsed low mid-period while locked -> all outputs 0 immediately; the first post-reset tick gives no period_valid.
